// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch front end.
//   - state_e    : fetch FSM states
//   - OP_BCOND   : conditional branch opcode, instr[15:12]
//   - OP_B       : unconditional branch opcode, instr[15:11]
//   - InstrWidth : instruction width in bits
package cpu_pkg;

  localparam int unsigned InstrWidth = 16;

  localparam logic [3:0] OP_BCOND = 4'b1101;
  localparam logic [4:0] OP_B     = 5'b11100;

  typedef enum logic [1:0] {
    StFetch,
    StIssue,
    StInject,
    StHalt
  } state_e;

endpackage

// File: rtl/branch_target.sv
// Branch target adder.
//   pc_i     : address of the branch instruction
//   instr_i  : branch instruction
//   target_o : pc + 4 + (sign-extended offset << 1), modulo 2^16
// An OP_B instruction uses the 11-bit offset; everything else is treated as a
// conditional branch with an 8-bit offset. The caller decides whether it is taken.
module branch_target
  import cpu_pkg::*;
(
  input  logic [15:0]           pc_i,
  input  logic [InstrWidth-1:0] instr_i,
  output logic [15:0]           target_o
);

  logic [15:0] offset;

  always_comb begin
    if (instr_i[15:11] == OP_B) begin
      offset = {{4{instr_i[10]}}, instr_i[10:0], 1'b0};
    end else begin
      offset = {{7{instr_i[7]}}, instr_i[7:0], 1'b0};
    end
    target_o = pc_i + 16'd4 + offset;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   imem_req_o/addr_o      : instruction memory request and byte address
//   imem_ack_i/data_i      : memory response (only honoured while fetching)
//   stall_i                : downstream hold while an instruction is presented
//   branch_i               : conditional branch taken, from the control unit
//   self_instruct_en_i/_i  : inject request and instruction, from the control unit
//   end_program_i          : halt request, from the control unit
//   instr_o, cu_input_en_o : instruction presented to the control unit, and its valid
//   pc_o                   : address of instr_o
//   halted_o               : program ended; only reset leaves this state
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned MAX_INJECT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [15:0]           imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [InstrWidth-1:0] imem_data_i,
  input  logic                  stall_i,
  input  logic                  branch_i,
  input  logic                  self_instruct_en_i,
  input  logic [InstrWidth-1:0] self_instruct_i,
  input  logic                  end_program_i,
  output logic [InstrWidth-1:0] instr_o,
  output logic                  cu_input_en_o,
  output logic [15:0]           pc_o,
  output logic                  halted_o
);

  localparam int unsigned CntW = (MAX_INJECT > 0) ? $clog2(MAX_INJECT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_INJECT);

  state_e                state_q, state_d;
  logic [15:0]           pc_q, pc_d;
  logic [InstrWidth-1:0] instr_q, instr_d;
  logic [CntW-1:0]       inject_cnt_q, inject_cnt_d;

  logic [15:0] target;
  logic        presenting;
  logic        branch_taken;

  branch_target u_branch_target (
    .pc_i     (pc_q),
    .instr_i  (instr_q),
    .target_o (target)
  );

  assign presenting   = (state_q == StIssue) || (state_q == StInject);
  // Unconditional branches are decoded here; conditional ones need the CU's verdict.
  assign branch_taken = (instr_q[15:11] == OP_B) ||
                        (branch_i && (instr_q[15:12] == OP_BCOND));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    inject_cnt_d = inject_cnt_q;

    unique case (state_q)
      StFetch: begin
        if (imem_ack_i) begin
          instr_d = imem_data_i;
          state_d = StIssue;
        end
      end
      StIssue, StInject: begin
        if (!stall_i) begin
          if (end_program_i) begin
            state_d = StHalt;
          end else if (branch_taken) begin
            pc_d         = target;
            inject_cnt_d = '0;
            state_d      = StFetch;
          end else if (self_instruct_en_i && (inject_cnt_q != CntMax)) begin
            instr_d      = self_instruct_i;
            inject_cnt_d = inject_cnt_q + CntW'(1);
            state_d      = StInject;
          end else begin
            // Also reached when the inject budget is spent: force progress.
            pc_d         = pc_q + 16'd2;
            inject_cnt_d = '0;
            state_d      = StFetch;
          end
        end
      end
      StHalt: begin
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      inject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      inject_cnt_q <= inject_cnt_d;
    end
  end

  // Request is gated by reset so it drops the instant reset asserts, not at the next edge.
  assign imem_req_o    = rst_ni && (state_q == StFetch);
  assign imem_addr_o   = pc_q;
  assign cu_input_en_o = presenting;
  assign instr_o       = presenting ? instr_q : '0;
  assign pc_o          = pc_q;
  assign halted_o      = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [15:0] imem_data_i = 16'h0000;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        self_instruct_en_i = 1'b0;
  logic [15:0] self_instruct_i = 16'h0000;
  logic        end_program_i = 1'b0;
  logic [15:0] instr_o;
  logic        cu_input_en_o;
  logic [15:0] pc_o;
  logic        halted_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk_i = ~clk_i;

  instr_fetch #(
    .RESET_PC   (16'h0000),
    .MAX_INJECT (4)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .imem_req_o         (imem_req_o),
    .imem_addr_o        (imem_addr_o),
    .imem_ack_i         (imem_ack_i),
    .imem_data_i        (imem_data_i),
    .stall_i            (stall_i),
    .branch_i           (branch_i),
    .self_instruct_en_i (self_instruct_en_i),
    .self_instruct_i    (self_instruct_i),
    .end_program_i      (end_program_i),
    .instr_o            (instr_o),
    .cu_input_en_o      (cu_input_en_o),
    .pc_o               (pc_o),
    .halted_o           (halted_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MFetch   = 0;  // waiting for memory
  localparam int MPresent = 1;  // instruction visible to the control unit
  localparam int MHalt    = 2;
  localparam int MaxInj   = 4;

  int m_mode  = MFetch;
  int m_pc    = 0;
  int m_instr = 0;
  int m_run   = 0;  // consecutive injects accepted

  function automatic bit is_uncond(input int ins);
    return ((ins >> 11) & 31) == 28;
  endfunction

  function automatic int br_target(input int pc, input int ins);
    int o;
    if (is_uncond(ins)) begin
      o = ins & 'h7FF;
      if (o >= 1024) o -= 2048;
    end else begin
      o = ins & 'hFF;
      if (o >= 128) o -= 256;
    end
    return (pc + 4 + 2 * o) & 'hFFFF;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_mode = MFetch; m_pc = 0; m_instr = 0; m_run = 0;
    end else if (m_mode == MFetch) begin
      if (imem_ack_i) begin
        m_instr = int'(imem_data_i);
        m_mode  = MPresent;
      end
    end else if (m_mode == MPresent && !stall_i) begin
      if (end_program_i) begin
        m_mode = MHalt;
      end else if (is_uncond(m_instr) || (branch_i && ((m_instr >> 12) & 15) == 13)) begin
        m_pc = br_target(m_pc, m_instr); m_run = 0; m_mode = MFetch;
      end else if (self_instruct_en_i && m_run < MaxInj) begin
        m_instr = int'(self_instruct_i); m_run++;
      end else begin
        m_pc = (m_pc + 2) & 'hFFFF; m_run = 0; m_mode = MFetch;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("cmp_req", imem_req_o, rst_ni && m_mode == MFetch);
      if (rst_ni && m_mode == MFetch) check("cmp_addr", imem_addr_o, m_pc);
      check("cmp_valid", cu_input_en_o, m_mode == MPresent);
      check("cmp_instr", instr_o, (m_mode == MPresent) ? (m_instr & 'hFFFF) : 0);
      check("cmp_pc", pc_o, m_pc);
      check("cmp_halted", halted_o, m_mode == MHalt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic sync();
    @(posedge clk_i);
    #2;
  endtask

  // Wait (bounded) for a request, then acknowledge it for one edge.
  task automatic do_fetch(input logic [15:0] d);
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin
      sync();
      n++;
    end
    if (imem_req_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL fetch_wait: req=%b, required 1", imem_req_o);
    end
    imem_ack_i  = 1'b1;
    imem_data_i = d;
    sync();
    imem_ack_i  = 1'b0;
    imem_data_i = 16'hFFFF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_req", imem_req_o, 0);
    check("rst_valid", cu_input_en_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_halted", halted_o, 0);
    check("rst_pc", pc_o, 16'h0000);
    rst_ni = 1'b1;
    #1;
    check("first_req", imem_req_o, 1);
    check("first_addr", imem_addr_o, 16'h0000);
    sync();

    // Straight-line: one presentation cycle, then fetch pc+2.
    do_fetch(16'h1C08);
    #1;
    check("seq_valid", cu_input_en_o, 1);
    check("seq_pc", pc_o, 16'h0000);
    check("seq_instr", instr_o, 16'h1C08);
    sync();
    check("seq_next_req", imem_req_o, 1);
    check("seq_next_addr", imem_addr_o, 16'h0002);
    check("model_seq_pc", m_pc, 2);

    // Unconditional branch 2+4+10 = 0x10.
    do_fetch(16'hE005);
    sync();
    check("ub_addr", imem_addr_o, 16'h0010);

    // Conditional branch held through a 3-cycle stall, then taken to 0x10+4-4.
    branch_i = 1'b1;
    do_fetch(16'hD0FE);
    stall_i = 1'b1;
    repeat (3) begin
      #1;
      check("stall_instr", instr_o, 16'hD0FE);
      check("stall_valid", cu_input_en_o, 1);
      check("stall_pc", pc_o, 16'h0010);
      sync();
    end
    stall_i = 1'b0;
    sync();
    branch_i = 1'b0;
    check("bc_req", imem_req_o, 1);
    check("bc_addr", imem_addr_o, 16'h0010);

    // Backward jump to 0xFFFC, then a forward jump that wraps to 0x07FE.
    do_fetch(16'hE7F4);
    sync();
    check("neg_addr", imem_addr_o, 16'hFFFC);
    check("model_neg_pc", m_pc, 'hFFFC);
    do_fetch(16'hE3FF);
    sync();
    check("wrap_addr", imem_addr_o, 16'h07FE);
    check("model_wrap_pc", m_pc, 'h07FE);

    // Continuous inject request: 4 injects accepted, the 5th advances the pc.
    self_instruct_en_i = 1'b1;
    self_instruct_i    = 16'h9701;
    do_fetch(16'h1234);
    #1;
    check("inj_issue_instr", instr_o, 16'h1234);
    @(posedge clk_i);
    #2;
    #1;
    check("inj_instr", instr_o, 16'h9701);
    check("inj_pc", pc_o, 16'h07FE);
    check("inj_valid", cu_input_en_o, 1);
    repeat (4) @(posedge clk_i);
    #2;
    self_instruct_en_i = 1'b0;
    check("inj_limit_req", imem_req_o, 1);
    check("inj_limit_addr", imem_addr_o, 16'h0800);
    check("model_inj_pc", m_pc, 'h0800);

    // End-of-program wins over a taken branch; halt ignores memory acks.
    end_program_i = 1'b1;
    branch_i      = 1'b1;
    do_fetch(16'hD0FE);
    sync();
    end_program_i = 1'b0;
    branch_i      = 1'b0;
    check("halt_flag", halted_o, 1);
    check("halt_req", imem_req_o, 0);
    imem_ack_i = 1'b1;
    repeat (3) sync();
    imem_ack_i = 1'b0;
    check("halt_stay", halted_o, 1);
    check("halt_pc", pc_o, 16'h0800);

    // Reset leaves halt.
    rst_ni = 1'b0;
    #1;
    check("halt_rst_flag", halted_o, 0);
    sync();
    rst_ni = 1'b1;

    // Reset while an ack is present: no capture, request drops immediately.
    imem_ack_i  = 1'b1;
    imem_data_i = 16'hD0FE;
    rst_ni      = 1'b0;
    #1;
    check("rstack_req", imem_req_o, 0);
    sync();
    rst_ni     = 1'b1;
    imem_ack_i = 1'b0;
    #1;
    check("rstack_valid", cu_input_en_o, 0);
    check("rstack_instr", instr_o, 0);
    check("rstack_req_back", imem_req_o, 1);
    check("rstack_addr", imem_addr_o, 16'h0000);
    sync();
    do_fetch(16'h1C08);
    #1;
    check("resume_instr", instr_o, 16'h1C08);
    check("resume_pc", pc_o, 16'h0000);
    sync();
    sync();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the byte address of the first fetch after reset.
REQ-002 SHALL have parameter MAX_INJECT, default 4, meaning the maximum number of consecutive self-instructions accepted before forced PC advance.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports ordered and defined as follows:
- clk_i  in  1  clock; rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  16  byte address of the request.
- imem_ack_i  in  1  memory data valid.
- imem_data_i  in  16  fetched instruction.
- stall_i  in  1  downstream hold.
- branch_i  in  1  conditional branch taken, from the control unit.
- self_instruct_en_i  in  1  inject request, from the control unit.
- self_instruct_i  in  16  instruction to inject.
- end_program_i  in  1  halt request, from the control unit.
- instr_o  out  16  instruction presented to the control unit.
- cu_input_en_o  out  1  instr_o valid.
- pc_o  out  16  address of instr_o.
- halted_o  out  1  program ended.

Function
REQ-004 SHALL implement FSM states FETCH, ISSUE, INJECT and HALT.
REQ-005 In FETCH, the block SHALL drive imem_req_o=1 and imem_addr_o=pc; on imem_ack_i it SHALL capture imem_data_i into instr_q and go to ISSUE the next cycle.
REQ-006 imem_ack_i SHALL be ignored outside FETCH.
REQ-007 In ISSUE and INJECT, the block SHALL drive cu_input_en_o=1 and instr_o=instr_q; in all other states instr_o SHALL be 0 and cu_input_en_o SHALL be 0.
REQ-008 While stall_i=1 in ISSUE or INJECT, the block SHALL hold state, instr_q and pc, and SHALL ignore all control-unit feedback.
REQ-009 On a non-stalled ISSUE or INJECT cycle, the block SHALL sample feedback with this fixed priority: end_program_i, then branch taken, then self_instruct_en_i, then normal advance.
REQ-010 On end_program_i, the block SHALL go to HALT.
REQ-011 Branch taken SHALL be either branch_i=1 with instr_q[15:12]=4'b1101, or instr_q[15:11]=5'b11100 (unconditional, decoded locally).
REQ-012 Branch target arithmetic:
- Conditional: pc+4+(sext(instr_q[7:0])<<1).
- Unconditional: pc+4+(sext(instr_q[10:0])<<1).
- Result taken modulo 2^16; wrap-around is legal.
REQ-013 On branch taken, the block SHALL set pc to the target and go to FETCH.
REQ-014 On self-inject, the block SHALL load instr_q with self_instruct_i, go to INJECT, leave pc unchanged and increment inject_cnt.
REQ-015 A self_instruct_en_i received while inject_cnt==MAX_INJECT SHALL be treated as normal advance.
REQ-016 On normal advance, the block SHALL set pc to pc+2 (mod 2^16), clear inject_cnt and go to FETCH.
REQ-017 pc_o SHALL equal pc at all times, including during INJECT.
REQ-018 In HALT: imem_req_o=0, halted_o=1, all inputs ignored; the only exit is reset.
REQ-019 Minimum latency from ack to the next fetch request on straight-line code SHALL be 2 cycles (ISSUE, then FETCH).

Reset
REQ-020 While rst_ni=0, asynchronously:
- State=FETCH, pc=RESET_PC, instr_q=0, inject_cnt=0.
- imem_req_o=0 while reset is asserted.
- cu_input_en_o=0, instr_o=0, halted_o=0.
REQ-021 After rst_ni deasserts, the first request with imem_addr_o=RESET_PC SHALL appear on the first rising edge.
REQ-022 Reset mid-fetch or mid-inject SHALL abandon the operation; a late imem_ack_i SHALL be ignored until FETCH is re-entered.

Structure
REQ-023 A shared package cpu_pkg SHALL hold:
- the FSM state enum;
- opcode constants OP_BCOND=4'b1101 and OP_B=5'b11100;
- the instruction width of 16.
REQ-024 Branch target computation SHALL be a sub-module named branch_target (pc, instr -> target).

Verification
REQ-025 Reset then ack 16'h1C08 at 16'h0000 -> cu_input_en_o for 1 cycle with pc_o=0, then imem_addr_o=16'h0002.
REQ-026 instr_q=16'hD0FE at pc 16'h0010 with branch_i=1 -> next imem_addr_o=16'h0010 (offset -2 -> 0x10+4-4).
REQ-027 instr_q=16'hE3FF at pc 16'hFFFC -> target wraps to 16'h07FE.
REQ-028 self_instruct_en_i=1, self_instruct_i=16'h9701 -> INJECT cycle with instr_o=16'h9701 and pc_o unchanged; a 5th consecutive inject request is treated as normal advance to pc+2.
REQ-029 end_program_i and branch_i together in ISSUE -> HALT, halted_o=1, no further imem_req_o; stall_i=1 for 3 cycles in ISSUE -> instr_o stable and feedback ignored.
REQ-030 Assert rst_ni=0 during FETCH while imem_ack_i=1 -> no capture; imem_req_o=0 immediately.
